jtframe_sigma_dac: RTL and testbench

- Parametrised multi-channel 1-bit sigma-delta audio DAC for jtframe platform tops.
- Generalises the fixed stereo hifi DAC path: channel count, sample width, signedness and clock-enable rate are parameters.
- Adds a pop-free mute/unmute gain ramp and a global attenuation shift.
- Sits between the game's sound outputs and the board's PWM audio pins.

---
 rtl/jtframe_sigma_dac.sv | 123 ++++++++++++
 tb/tb_jtframe_sigma_dac.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_sigma_dac.sv
// Multi-channel first-order sigma-delta audio DAC with a pop-free mute ramp
// and a global attenuation shift, all state advancing on a divided clock enable.
module jtframe_sigma_dac #(
  parameter int unsigned CH         = 2,
  parameter int unsigned W          = 16,
  parameter int unsigned SIGNED_SND = 1,
  parameter int unsigned CEN_DIV    = 4
) (
  input  logic            clk_dac,
  input  logic            rst,
  input  logic [CH*W-1:0] snd,
  input  logic            mute,
  input  logic [2:0]      att,
  output logic [CH-1:0]   dac_out,
  output logic [7:0]      level,
  output logic            ramp_busy
);

  typedef enum logic [1:0] {MUTED, RAMP_UP, ON, RAMP_DOWN} state_t;

  localparam int unsigned CW = $clog2(CEN_DIV);
  localparam int unsigned WP = W + 10;
  localparam logic [W-1:0]        FLIP = (SIGNED_SND != 0) ? (W'(1) << (W-1)) : '0;
  localparam logic [W-1:0]        HALF = W'(1) << (W-1);
  localparam logic signed [W:0]   MID  = (W+1)'(2**(W-1));

  logic [CW-1:0] cnt_q;
  logic          cen;
  state_t        state_q, state_d;
  logic [7:0]    level_q, level_d, level_up, level_dn;
  logic          busy_q;
  logic [CH-1:0] dac_q;
  logic [W-1:0]  h_d   [CH];
  logic [W-1:0]  h_q   [CH];
  logic [W-1:0]  acc_q [CH];
  logic signed [8:0] lvl_s;

  assign cen      = (cnt_q == CW'(CEN_DIV - 1));
  assign lvl_s    = $signed({1'b0, level_q});
  assign level_up = (level_q == 8'hFF) ? level_q : level_q + 8'd1;
  assign level_dn = (level_q == 8'h00) ? level_q : level_q - 8'd1;

  // Endpoint checks come first so they win over a simultaneous mute change.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      MUTED: if (!mute) begin
        state_d = RAMP_UP;
        level_d = level_up;
      end
      RAMP_UP: begin
        if (level_q == 8'hFF) begin
          state_d = ON;
        end else if (mute) begin
          state_d = RAMP_DOWN;
          level_d = level_dn;
        end else begin
          level_d = level_up;
        end
      end
      ON: if (mute) begin
        state_d = RAMP_DOWN;
        level_d = level_dn;
      end
      RAMP_DOWN: begin
        if (level_q == 8'h00) begin
          state_d = MUTED;
        end else if (!mute) begin
          state_d = RAMP_UP;
          level_d = level_up;
        end else begin
          level_d = level_dn;
        end
      end
      default: state_d = MUTED;
    endcase
  end

  for (genvar n = 0; n < CH; n++) begin : g_ch
    logic [W-1:0]         u;
    logic signed [W:0]    c, g, a;
    logic signed [WP-1:0] p;

    assign u = snd[n*W +: W] ^ FLIP;
    assign c = $signed({1'b0, u}) - MID;
    assign p = WP'(c) * WP'(lvl_s);
    // Full gain bypasses the multiplier so ON is bit-exact.
    assign g = (state_q == ON) ? c : (W+1)'(p >>> 8);
    assign a = g >>> att;
    assign h_d[n] = (state_q == MUTED) ? HALF : W'(a + MID);
  end

  always_ff @(posedge clk_dac) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= MUTED;
      level_q <= '0;
      busy_q  <= 1'b0;
      dac_q   <= '0;
      for (int unsigned n = 0; n < CH; n++) begin
        h_q[n]   <= '0;
        acc_q[n] <= '0;
      end
    end else begin
      cnt_q <= cen ? '0 : cnt_q + CW'(1);
      if (cen) begin
        state_q <= state_d;
        level_q <= level_d;
        busy_q  <= (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
        for (int unsigned n = 0; n < CH; n++) begin
          {dac_q[n], acc_q[n]} <= {1'b0, acc_q[n]} + {1'b0, h_q[n]};
          h_q[n] <= h_d[n];
        end
      end
    end
  end

  assign dac_out   = dac_q;
  assign level     = level_q;
  assign ramp_busy = busy_q;

endmodule

// File: tb/tb_jtframe_sigma_dac.sv
// Bench for jtframe_sigma_dac: two instances (16-bit signed /4, 4-bit offset /2)
// checked every clock against an arithmetic model, plus literal density/ramp checks.
module tb_jtframe_sigma_dac;

  localparam int S_MUTED = 0, S_UP = 1, S_ON = 2, S_DOWN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mute = 1'b1;
  logic [2:0]  att = 3'd0;
  logic [31:0] snd16 = '0;
  logic [7:0]  snd4 = '0;
  logic [1:0]  dac16, dac4;
  logic [7:0]  level16, level4;
  logic        busy16, busy4;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;

  int m_st  [2];
  int m_lvl [2];
  int m_cnt [2];
  int m_h   [2][2];
  int m_acc [2][2];
  int m_dac [2][2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  jtframe_sigma_dac #(.CH(2), .W(16), .SIGNED_SND(1), .CEN_DIV(4)) u_dac16 (
    .clk_dac(clk), .rst(rst), .snd(snd16), .mute(mute), .att(att),
    .dac_out(dac16), .level(level16), .ramp_busy(busy16));

  jtframe_sigma_dac #(.CH(2), .W(4), .SIGNED_SND(0), .CEN_DIV(2)) u_dac4 (
    .clk_dac(clk), .rst(rst), .snd(snd4), .mute(mute), .att(att),
    .dac_out(dac4), .level(level4), .ramp_busy(busy4));

  function automatic int p_w(input int i);      return (i == 0) ? 16 : 4; endfunction
  function automatic int p_signed(input int i); return (i == 0) ? 1 : 0;  endfunction
  function automatic int p_cen(input int i);    return (i == 0) ? 4 : 2;  endfunction

  function automatic int fdiv(input int x, input int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  task automatic ramp_step(input int i);
    case (m_st[i])
      S_MUTED: if (!mute) begin m_st[i] = S_UP; m_lvl[i] = 1; end
      S_UP: begin
        if (m_lvl[i] == 255) m_st[i] = S_ON;
        else if (mute) begin m_st[i] = S_DOWN; m_lvl[i] = m_lvl[i] - 1; end
        else m_lvl[i] = m_lvl[i] + 1;
      end
      S_ON: if (mute) begin m_st[i] = S_DOWN; m_lvl[i] = 254; end
      default: begin
        if (m_lvl[i] == 0) m_st[i] = S_MUTED;
        else if (!mute) begin m_st[i] = S_UP; m_lvl[i] = m_lvl[i] + 1; end
        else m_lvl[i] = m_lvl[i] - 1;
      end
    endcase
  endtask

  task automatic model_step(input int i);
    int w, half, full, s, c, g, a, sum;
    w = p_w(i);
    half = 1 << (w - 1);
    full = 1 << w;
    if (rst) begin
      m_cnt[i] = 0; m_st[i] = S_MUTED; m_lvl[i] = 0;
      for (int ch = 0; ch < 2; ch++) begin
        m_h[i][ch] = 0; m_acc[i][ch] = 0; m_dac[i][ch] = 0;
      end
    end else if (m_cnt[i] < p_cen(i) - 1) begin
      m_cnt[i] = m_cnt[i] + 1;
    end else begin
      m_cnt[i] = 0;
      for (int ch = 0; ch < 2; ch++) begin
        sum = m_acc[i][ch] + m_h[i][ch];
        m_dac[i][ch] = (sum >= full) ? 1 : 0;
        m_acc[i][ch] = sum % full;
        s = (i == 0) ? int'(snd16[ch*16 +: 16]) : int'(snd4[ch*4 +: 4]);
        if (p_signed(i) != 0) c = (s >= half) ? s - full : s;
        else c = s - half;
        g = (m_st[i] == S_ON) ? c : fdiv(c * m_lvl[i], 256);
        a = fdiv(g, 1 << att);
        m_h[i][ch] = (m_st[i] == S_MUTED) ? half : a + half;
      end
      ramp_step(i);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic check(input string name, input int got, input int exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int busy_of(input int st);
    return (st == S_UP || st == S_DOWN) ? 1 : 0;
  endfunction

  // Every bench wait goes through here so all outputs are compared each clock.
  task automatic tick();
    @(negedge clk);
    check("dac16",   int'(dac16),   m_dac[0][1] * 2 + m_dac[0][0]);
    check("level16", int'(level16), m_lvl[0]);
    check("busy16",  int'(busy16),  busy_of(m_st[0]));
    check("dac4",    int'(dac4),    m_dac[1][1] * 2 + m_dac[1][0]);
    check("level4",  int'(level4),  m_lvl[1]);
    check("busy4",   int'(busy4),   busy_of(m_st[1]));
  endtask

  task automatic count_ones(input int n, output int a0, output int a1,
                            output int b0, output int b1);
    a0 = 0; a1 = 0; b0 = 0; b1 = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      a0 += int'(dac16[0]); a1 += int'(dac16[1]);
      b0 += int'(dac4[0]);  b1 += int'(dac4[1]);
    end
  endtask

  task automatic wait_level_change(input int bound);
    int prev;
    prev = int'(level16);
    for (int k = 0; k < bound && int'(level16) == prev; k++) tick();
  endtask

  logic [31:0] vec16 [4] = '{32'h7FFF_8000, 32'h0001_FFFF, 32'hEDCB_1234, 32'h0000_4000};
  int          vatt  [4] = '{0, 7, 3, 5};

  initial begin
    int a0, a1, b0, b1, t_rise;

    repeat (3) tick();
    check("rst_level", int'(level16), 0);
    check("rst_busy",  int'(busy16), 0);
    check("rst_dac16", int'(dac16), 0);
    check("rst_dac4",  int'(dac4), 0);
    rst = 1'b0;

    // Muted: h is mid-scale, so output alternates one cen high, one low.
    repeat (16) tick();
    count_ones(2000, a0, a1, b0, b1);
    check("mute50_ch0", a0, 1000);
    check("mute50_ch1", a1, 1000);

    mute = 1'b0;
    for (int k = 0; k < 10 && !busy16; k++) tick();
    check("unmute_busy", int'(busy16), 1);
    check("unmute_lvl1", int'(level16), 1);
    t_rise = cyc_cnt;
    for (int k = 0; k < 1100 && level16 != 8'd255; k++) tick();
    check("ramp_clocks", cyc_cnt - t_rise, 1016);
    repeat (4) tick();
    check("on_busy", int'(busy16), 0);
    check("on_level", int'(level16), 255);

    snd4 = 8'hF3;
    repeat (8) tick();
    count_ones(32, a0, a1, b0, b1);
    check("w4_snd3", b0, 6);
    check("w4_snd15", b1, 30);
    snd4 = 8'h00;
    repeat (8) tick();
    count_ones(32, a0, a1, b0, b1);
    check("w4_snd0_ch0", b0, 0);
    check("w4_snd0_ch1", b1, 0);

    att = 3'd1;
    snd16 = 32'h0000_4000;
    repeat (16) tick();
    count_ones(32, a0, a1, b0, b1);
    check("att1_hA000", a0, 20);
    check("att1_h8000", a1, 16);

    for (int v = 0; v < 4; v++) begin
      snd16 = vec16[v];
      att = vatt[v][2:0];
      snd4 = 8'($urandom);
      repeat (40) tick();
    end

    // Scaled path exercised through ramps with non-trivial samples.
    snd16 = 32'h3ABC_C123;
    snd4 = 8'h5A;
    att = 3'd2;
    mute = 1'b1;
    for (int k = 0; k < 1200 && !(level16 == 8'd0 && !busy16); k++) tick();
    check("down_done", int'(level16), 0);

    mute = 1'b0;
    for (int k = 0; k < 500 && level16 != 8'd100; k++) tick();
    check("reach100", int'(level16), 100);
    mute = 1'b1;
    wait_level_change(10);
    check("rev_99", int'(level16), 99);
    for (int k = 0; k < 300 && level16 != 8'd50; k++) tick();
    check("reach50", int'(level16), 50);
    mute = 1'b0;
    wait_level_change(10);
    check("rev_51", int'(level16), 51);
    for (int k = 0; k < 600 && level16 != 8'd180; k++) tick();
    check("reach180", int'(level16), 180);

    rst = 1'b1;
    tick();
    check("rstmid_level", int'(level16), 0);
    check("rstmid_busy", int'(busy16), 0);
    check("rstmid_dac", int'(dac16), 0);
    rst = 1'b0;
    wait_level_change(12);
    check("restart_lvl1", int'(level16), 1);
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
